load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous reset, active-high).
REQ-002 Request-side ports SHALL be:
- req_valid input 1: request present.
- req_ready output 1: unit can accept a request.
- req_is_store input 1: 1 = store, 0 = load.
- req_funct3 input 3: RV32I width/sign code.
- req_addr input 32: byte address.
- req_wdata input 32: store data (rs2).
- req_rd input 5: load destination register.
REQ-003 Data-memory bus ports SHALL be:
- mem_valid output 1: bus request active.
- mem_we output 1: write request.
- mem_addr output 32: word address, bits [1:0] = 0.
- mem_wdata output 32: lane-aligned store data.
- mem_wstrb output 4: byte enables.
- mem_ready input 1: bus completes the request this cycle.
- mem_rdata input 32: read word, valid when mem_valid && mem_ready.
REQ-004 Register-file write port and status ports SHALL be:
- wb_en output 1: write-enable pulse.
- wb_rd output 5: destination register.
- wb_data output 32: formatted load data.
- stall output 1: pipeline hold.
- misalign_err output 1: one-cycle fault pulse.

Function
REQ-005 The FSM SHALL have three states: IDLE, BUS, RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; stall SHALL be 1 in BUS and RESP and SHALL equal the inverse of req_ready.
REQ-007 On req_valid && req_ready, the unit SHALL latch is_store, funct3, addr, wdata and rd.
REQ-008 A legal accepted request SHALL move IDLE->BUS.
- Legal loads: funct3 in {000, 001, 010, 100, 101}.
- Legal stores: funct3 in {000, 001, 010}.
- Alignment: halfword requires addr[0] = 0; word requires addr[1:0] = 00.
REQ-009 An accepted illegal or misaligned request SHALL stay in IDLE, SHALL pulse misalign_err for exactly the next cycle, and SHALL cause no bus access and no wb_en.
REQ-010 In BUS, bus outputs SHALL behave as follows:
- mem_valid = 1 and mem_addr = {addr[31:2], 2'b00}.
- mem_we = is_store.
- All bus outputs held stable until mem_ready.
REQ-011 mem_valid SHALL be 0 in IDLE and RESP.
REQ-012 Store lane steering SHALL be:
- SB: mem_wdata = wdata[7:0] replicated 4x; mem_wstrb = 4'b0001 << addr[1:0].
- SH: mem_wdata = wdata[15:0] replicated 2x; mem_wstrb = 4'b0011 << addr[1:0].
- SW: mem_wdata = wdata; mem_wstrb = 4'b1111.
- Loads: mem_wstrb = 4'b0000.
REQ-013 In BUS with mem_ready = 1, the next state SHALL be RESP; for a load, mem_rdata SHALL be captured on that same edge.
REQ-014 In BUS with mem_ready = 0, the state SHALL remain BUS for an unbounded wait.
REQ-015 In RESP, a load SHALL drive wb_en = (rd != 0), wb_rd = rd and wb_data = the formatted value for exactly one cycle; a store SHALL drive wb_en = 0.
REQ-016 RESP SHALL always return to IDLE on the next edge.
REQ-017 Load formatting, with the selected lane taken from addr[1:0]:
- LB: sign-extend the selected byte.
- LBU: zero-extend the selected byte.
- LH: sign-extend the selected halfword.
- LHU: zero-extend the selected halfword.
- LW: full word.
REQ-018 Outside RESP, wb_en SHALL be 0 and wb_data and wb_rd SHALL be 0.
REQ-019 Timing for a load accepted at edge N with mem_ready high in the first BUS cycle:
- Edge N: request accepted.
- Cycle N+1: mem_valid = 1.
- Cycle N+2: wb_en = 1.
- Cycle N+3: req_ready = 1.
REQ-020 req_valid asserted while req_ready = 0 SHALL be ignored; the upstream stage holds the request.

Reset
REQ-021 On rst = 1 at a rising edge, the unit SHALL reset as follows:
- State = IDLE.
- All latched fields = 0.
- mem_valid, mem_we, wb_en, misalign_err and stall = 0.
- req_ready = 1 from the following cycle.
REQ-022 Reset asserted in BUS or RESP SHALL abort the operation: no wb_en, and a mem_ready arriving in the same cycle as rst is discarded.
REQ-023 rst SHALL take priority over req_valid and mem_ready in the same cycle.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- LB addr 0x1003, mem_rdata 0x80FF_1234, mem_ready high first cycle, rd = 5 -> wb_en pulse at N+2, wb_rd = 5, wb_data = 0xFFFF_FF80.
- LHU addr 0x2002, mem_rdata 0xBEEF_0000, mem_ready delayed 3 cycles -> mem_valid high 4 cycles, mem_addr = 0x2000, wb_data = 0x0000_BEEF, stall high throughout.
- SB addr 0x3001, wdata 0x0000_00AB -> mem_we = 1, mem_wstrb = 0010, mem_wdata = 0xABAB_ABAB, wb_en stays 0.
- LW addr 0x4002 -> misalign_err single-cycle pulse, mem_valid never asserts, req_ready high next cycle.
- LW with rd = 0, mem_rdata 0x1234_5678 -> RESP occurs, wb_en = 0.
- rst asserted on the second BUS cycle with mem_ready = 1 -> mem_valid = 0 next cycle, no wb_en, req_ready = 1.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit with one outstanding data-memory access.
// Accepts one request in IDLE, issues one word-aligned bus access in BUS,
// then presents the formatted load result to the register file in RESP.
// Ports:
//   clk, rst                        rising-edge clock, synchronous active-high reset
//   req_valid/req_ready             request handshake (req_ready only in IDLE)
//   req_is_store, req_funct3        operation kind and RV32I width/sign code
//   req_addr, req_wdata, req_rd     byte address, store data, load destination
//   mem_valid/mem_we/mem_addr       data-memory request (word address)
//   mem_wdata/mem_wstrb             lane-steered store data and byte enables
//   mem_ready/mem_rdata             bus completion and read word
//   wb_en/wb_rd/wb_data             one-cycle register-file write
//   stall                           pipeline hold while an access is in flight
//   misalign_err                    one-cycle pulse for an illegal/misaligned request
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        stall,
  output logic        misalign_err
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t            state, state_next;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [REG_W-1:0]  rd_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic              accept;
  logic              legal;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_fmt;

  assign accept = req_valid && (state == IDLE);

  // Legal width code for the direction, plus natural alignment of the address.
  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000:  legal = 1'b1;
      3'b001:  legal = ~req_addr[0];
      3'b010:  legal = (req_addr[1:0] == 2'b00);
      3'b100:  legal = ~req_is_store;
      3'b101:  legal = ~req_is_store & ~req_addr[0];
      default: legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Request latch, fault pulse and load-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
      end
      err_q <= accept && !legal;
      if (state == BUS && mem_ready && !is_store_q) rdata_q <= mem_rdata;
    end
  end

  // Bring the addressed byte/halfword down to bit 0, then extend.
  assign lane = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_fmt = '0;
    case (funct3_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_fmt = {24'h0, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_fmt = {16'h0, lane[15:0]};
      3'b010:  load_fmt = rdata_q;
      default: load_fmt = '0;
    endcase
  end

  // Next-state and output decode; everything is a function of registered state.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    stall        = 1'b1;
    mem_valid    = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = STRB_W'(0);
    wb_en        = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    misalign_err = err_q;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        stall     = 1'b0;
        if (accept && legal) state_next = BUS;
      end
      BUS: begin
        mem_valid = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        if (is_store_q) begin
          case (funct3_q[1:0])
            2'b00: begin
              mem_wdata = {4{wdata_q[7:0]}};
              mem_wstrb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
              mem_wdata = {2{wdata_q[15:0]}};
              mem_wstrb = 4'b0011 << addr_q[1:0];
            end
            default: begin
              mem_wdata = wdata_q;
              mem_wstrb = 4'b1111;
            end
          endcase
        end
        if (mem_ready) state_next = RESP;
      end
      RESP: begin
        if (!is_store_q) begin
          wb_en   = (rd_q != '0);
          wb_rd   = rd_q;
          wb_data = load_fmt;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit. Inputs change 1 ns
// after each rising edge; outputs are checked at that same point.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall;
  logic        misalign_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_rd       (req_rd),
    .mem_valid    (mem_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic request(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    req_rd       = rd;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; req_rd = '0; mem_ready = 1'b0; mem_rdata = '0;

    // Reset state
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_wb_en", 32'(wb_en), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    rst = 1'b0;
    step();

    // LB 0x1003, ready first cycle, rd=5
    request(1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5);
    step();                                   // edge N accepted
    req_valid = 1'b0;
    check("lb_mem_valid", 32'(mem_valid), 32'd1);
    check("lb_mem_addr", mem_addr, 32'h0000_1000);
    check("lb_mem_we", 32'(mem_we), 32'd0);
    check("lb_wstrb", 32'(mem_wstrb), 32'd0);
    check("lb_ready_low", 32'(req_ready), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h80FF_1234;
    step();                                   // N+2
    mem_ready = 1'b0; mem_rdata = '0;
    check("lb_wb_en", 32'(wb_en), 32'd1);
    check("lb_wb_rd", 32'(wb_rd), 32'd5);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    check("lb_resp_mem_valid", 32'(mem_valid), 32'd0);
    check("lb_resp_stall", 32'(stall), 32'd1);
    step();                                   // N+3
    check("lb_idle_ready", 32'(req_ready), 32'd1);
    check("lb_idle_wb_en", 32'(wb_en), 32'd0);
    check("lb_idle_wb_data", wb_data, 32'h0);

    // LHU 0x2002, ready after 3 wait cycles; a new request held upstream is ignored
    request(1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd7);
    step();
    request(1'b1, 3'b010, 32'h0000_9000, 32'hDEAD_BEEF, 5'd9);
    for (int i = 0; i < 3; i++) begin
      check("lhu_wait_mem_valid", 32'(mem_valid), 32'd1);
      check("lhu_wait_mem_addr", mem_addr, 32'h0000_2000);
      check("lhu_wait_mem_we", 32'(mem_we), 32'd0);
      check("lhu_wait_stall", 32'(stall), 32'd1);
      step();
    end
    req_valid = 1'b0;
    check("lhu_last_mem_valid", 32'(mem_valid), 32'd1);
    check("lhu_last_stall", 32'(stall), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hBEEF_0000;
    step();
    mem_ready = 1'b0; mem_rdata = '0;
    check("lhu_wb_en", 32'(wb_en), 32'd1);
    check("lhu_wb_rd", 32'(wb_rd), 32'd7);
    check("lhu_wb_data", wb_data, 32'h0000_BEEF);
    check("lhu_resp_stall", 32'(stall), 32'd1);
    step();
    check("lhu_idle_ready", 32'(req_ready), 32'd1);

    // SB 0x3001, wdata 0xAB
    request(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB, 5'd0);
    step();
    req_valid = 1'b0;
    check("sb_mem_we", 32'(mem_we), 32'd1);
    check("sb_wstrb", 32'(mem_wstrb), 32'h2);
    check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_mem_addr", mem_addr, 32'h0000_3000);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("sb_resp_wb_en", 32'(wb_en), 32'd0);
    check("sb_resp_mem_valid", 32'(mem_valid), 32'd0);
    step();

    // SH 0x3006, wdata 0x1234_CAFE
    request(1'b1, 3'b001, 32'h0000_3006, 32'h1234_CAFE, 5'd0);
    step();
    req_valid = 1'b0;
    check("sh_wstrb", 32'(mem_wstrb), 32'hC);
    check("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("sh_resp_wb_en", 32'(wb_en), 32'd0);
    step();

    // LW misaligned 0x4002
    request(1'b0, 3'b010, 32'h0000_4002, 32'h0, 5'd4);
    step();
    req_valid = 1'b0;
    check("lw_mis_err", 32'(misalign_err), 32'd1);
    check("lw_mis_mem_valid", 32'(mem_valid), 32'd0);
    check("lw_mis_ready", 32'(req_ready), 32'd1);
    step();
    check("lw_mis_err_clear", 32'(misalign_err), 32'd0);
    check("lw_mis_mem_valid2", 32'(mem_valid), 32'd0);
    check("lw_mis_wb_en", 32'(wb_en), 32'd0);

    // Store with load-only funct3 (100) is illegal
    request(1'b1, 3'b100, 32'h0000_4000, 32'h0, 5'd0);
    step();
    req_valid = 1'b0;
    check("sbu_err", 32'(misalign_err), 32'd1);
    check("sbu_mem_valid", 32'(mem_valid), 32'd0);
    step();

    // LH 0x5002 sign-extends upper halfword
    request(1'b0, 3'b001, 32'h0000_5002, 32'h0, 5'd12);
    step();
    req_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h9ABC_0000;
    step();
    mem_ready = 1'b0;
    check("lh_wb_data", wb_data, 32'hFFFF_9ABC);
    check("lh_wb_en", 32'(wb_en), 32'd1);
    step();

    // LW with rd = 0: RESP occurs but no write
    request(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd0);
    step();
    req_valid = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ready = 1'b0;
    check("lw_rd0_stall", 32'(stall), 32'd1);
    check("lw_rd0_wb_en", 32'(wb_en), 32'd0);
    check("lw_rd0_wb_data", wb_data, 32'h1234_5678);
    step();
    check("lw_rd0_idle", 32'(req_ready), 32'd1);

    // Reset during second BUS cycle with mem_ready high
    request(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd3);
    step();
    req_valid = 1'b0;
    check("rstbus_mem_valid1", 32'(mem_valid), 32'd1);
    step();
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    rst = 1'b0; mem_ready = 1'b0;
    check("rstbus_mem_valid", 32'(mem_valid), 32'd0);
    check("rstbus_wb_en", 32'(wb_en), 32'd0);
    check("rstbus_ready", 32'(req_ready), 32'd1);
    check("rstbus_stall", 32'(stall), 32'd0);
    step();
    check("rstbus_wb_en2", 32'(wb_en), 32'd0);
    check("rstbus_ready2", 32'(req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
